rotary_ctrl: RTL and testbench
==============================

// Module: rotary_ctrl
// PURPOSE
//  Front-panel rotary-encoder controller for the DDS generator.
//  - Decodes quadrature inputs Rot_A/Rot_B into up/down detent steps.
//  - Push button Rot_C cycles the step size.
//  - Keeps a 12-bit frequency-word address for the DDS.
//  - Pulses FreqChng for one cycle whenever that address changes.
// PARAMETERS
//  ADDR_W     12  width of Address
//  DEB_CYCLES 8   cycles a synchronised A/B level must stay stable before it is accepted
//  ADDR_RST   0   Address value after reset
// PORTS
//  Fg_CLK    in   1       system clock, 24 MHz; all logic on rising edge
//  RESET     in   1       reset, synchronous, active-high
//  Rot_A     in   1       encoder phase A, async, idle high
//  Rot_B     in   1       encoder phase B, async, idle high
//  Rot_C     in   1       push button, async, active high, may be 1 cycle wide
//  Address   out  ADDR_W  current frequency address
//  FreqChng  out  1       1-cycle strobe: Address changed this cycle
// BEHAVIOUR
//  - Reset values (RESET high at a clock edge):
//    Address=ADDR_RST, FreqChng=0, step index=0.
//    Debounced A and B are set to 1, synchronisers to 1, Rot_C edge register to 0.
//  - Input conditioning:
//    - Rot_A/Rot_B: 2-FF synchroniser, then a stability counter.
//      The debounced level updates after DEB_CYCLES consecutive equal samples.
//    - Rot_C: 2-FF synchroniser plus rising-edge detect, no debounce.
//      A 1-cycle input pulse must be caught.
//  - Detent decode, on the debounced falling edge of A:
//    - B=0 at that edge: B led, "plus", increment by step.
//    - B=1 at that edge: A led, "minus", decrement by step.
//    - A rising edge and all B edges: no action. One full A/B cycle gives exactly one step.
//  - Step size: index 0..3 selects 1, 10, 100, 1000.
//    Each Rot_C rising edge advances the index, and 3 wraps to 0.
//    A Rot_C edge in the same cycle as a detent: the detent uses the old step.
//  - Arithmetic: unsigned ADDR_W-bit, range 0..(2^ADDR_W-1).
//    Without ROTARY_WRAP_EN the result saturates:
//    - plus clamps to 4095.
//    - minus clamps to 0.
//  - Latency and strobe:
//    - Address takes its new value 1 cycle after the debounced A edge.
//    - FreqChng is high in that same cycle, and only if the new value differs from the old.
//      A saturated no-change step gives no strobe.
//  - RESET mid-rotation: reset wins. Partial A/B phases are discarded.
//    The next full detent after reset counts normally.
// CONFIGURATION
//  - ROTARY_WRAP_EN defined: add/subtract wrap modulo 2^ADDR_W.
//    Example: 4095+1 -> 0, 0-10 -> 4086.
//    FreqChng pulses on every detent.
//  - ROTARY_WRAP_EN undefined: saturate as above.
// STRUCTURE
//  - Package rotary_pkg holds:
//    - ADDR_W default.
//    - Step LUT constants STEP_0..STEP_3 = 1, 10, 100, 1000.
//    - Step index typedef (2 bits).
//  - Sub-module rot_debounce: synchroniser plus stability counter.
//    Instantiated for A and B; parameter DEB_CYCLES.
//  - Top holds Rot_C edge detect, step index, decode, adder/clamp and strobe.
// TESTING
//  1. Reset, then 2 minus detents (A falls first) at step 1
//     -> Address stays 0, FreqChng never pulses.
//  2. 2 plus detents (B falls first), 100 cycles per phase
//     -> Address 0->1->2, one FreqChng pulse each, 1 cycle after debounced A fall.
//  3. Five 1-cycle Rot_C pulses
//     -> step index goes 1,2,3,0,1 (step 10). Next plus -> Address 2->12.
//  4. Step 1000 from 12: plus x5 -> 1012, 2012, 3012, 4012, 4095 (clamped).
//     Sixth plus -> no change, no strobe.
//     With ROTARY_WRAP_EN: 4012+1000 -> 916.
//  5. A glitch shorter than DEB_CYCLES on Rot_A or Rot_B -> no step, no strobe.
//     RESET asserted between the A and B falls -> Address = ADDR_RST.
//     The next detent counts once.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared constants and types for the DDS front-panel rotary encoder controller.
package rotary_pkg;

  localparam int ADDR_W = 12;

  localparam int STEP_0 = 1;
  localparam int STEP_1 = 10;
  localparam int STEP_2 = 100;
  localparam int STEP_3 = 1000;

  typedef logic [1:0] step_idx_t;

  function automatic int step_of(step_idx_t idx);
    case (idx)
      2'd0:    return STEP_0;
      2'd1:    return STEP_1;
      2'd2:    return STEP_2;
      default: return STEP_3;
    endcase
  endfunction

endpackage

// File: rtl/rot_debounce.sv
// Two-flop synchroniser followed by a stability down-counter; the level is
// accepted once DEB_CYCLES consecutive synchronised samples disagree with it.
module rot_debounce #(
  parameter int DEB_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_level
);
  import rotary_pkg::*;

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= CNT_LOAD;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      // Any sample that agrees with the accepted level restarts the count.
      if (r_sync2 == r_level) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync2;
        r_cnt   <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/rotary_ctrl.sv
// Rotary encoder front panel: detent decode, step select and DDS address.
// Define ROTARY_WRAP_EN to make the address wrap instead of saturate.
module rotary_ctrl #(
  parameter int ADDR_W     = rotary_pkg::ADDR_W,
  parameter int DEB_CYCLES = 8,
  parameter logic [ADDR_W-1:0] ADDR_RST = '0
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic              Rot_A,
  input  logic              Rot_B,
  input  logic              Rot_C,
  output logic [ADDR_W-1:0] Address,
  output logic              FreqChng
);
  import rotary_pkg::*;

`ifdef ROTARY_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic              w_a_level;
  logic              w_b_level;
  logic              w_a_fall;
  logic              w_c_rise;
  logic [ADDR_W:0]   w_step;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W:0]   w_diff;
  logic [ADDR_W-1:0] w_addr_next;

  logic              r_a_prev;
  logic              r_c_sync1;
  logic              r_c_sync2;
  logic              r_c_prev;
  step_idx_t         r_step_idx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_freq_chng;

  rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .i_clk   (Fg_CLK),
    .i_rst   (RESET),
    .i_din   (Rot_A),
    .o_level (w_a_level)
  );

  rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .i_clk   (Fg_CLK),
    .i_rst   (RESET),
    .i_din   (Rot_B),
    .o_level (w_b_level)
  );

  assign w_a_fall = r_a_prev & ~w_a_level;
  assign w_c_rise = r_c_sync2 & ~r_c_prev;
  assign w_step   = (ADDR_W + 1)'(step_of(r_step_idx));
  assign w_sum    = {1'b0, r_addr} + w_step;
  assign w_diff   = {1'b0, r_addr} - w_step;

  // Only the debounced A fall is a detent; B low there means clockwise (plus).
  always_comb begin
    w_addr_next = r_addr;
    if (w_a_fall) begin
      if (!w_b_level) begin
        w_addr_next = (WRAP_EN || !w_sum[ADDR_W]) ? w_sum[ADDR_W-1:0] : {ADDR_W{1'b1}};
      end else begin
        w_addr_next = (WRAP_EN || !w_diff[ADDR_W]) ? w_diff[ADDR_W-1:0] : '0;
      end
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      r_a_prev    <= 1'b1;
      r_c_sync1   <= 1'b0;
      r_c_sync2   <= 1'b0;
      r_c_prev    <= 1'b0;
      r_step_idx  <= '0;
      r_addr      <= ADDR_RST;
      r_freq_chng <= 1'b0;
    end else begin
      r_a_prev    <= w_a_level;
      r_c_sync1   <= Rot_C;
      r_c_sync2   <= r_c_sync1;
      r_c_prev    <= r_c_sync2;
      // Detent in the same cycle still sees the old index via w_step.
      if (w_c_rise) begin
        r_step_idx <= r_step_idx + 1'b1;
      end
      r_addr      <= w_addr_next;
      r_freq_chng <= (w_addr_next != r_addr);
    end
  end

  assign Address  = r_addr;
  assign FreqChng = r_freq_chng;

endmodule

// File: tb/tb_rotary_ctrl.sv
// Scoreboard bench for rotary_ctrl: expected strobes are queued when A falls
// and matched against FreqChng/Address by a negedge monitor.
module tb_rotary_ctrl;

  localparam int ADDR_W = 12;
  localparam int DEB    = 8;
  localparam int LAT    = DEB + 3;
  localparam int PH     = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              a;
  logic              b;
  logic              c;
  logic [ADDR_W-1:0] addr;
  logic              fc;

  always #21 clk = ~clk;

  rotary_ctrl #(.ADDR_W(ADDR_W), .DEB_CYCLES(DEB), .ADDR_RST(12'd0)) dut (
    .Fg_CLK   (clk),
    .RESET    (rst),
    .Rot_A    (a),
    .Rot_B    (b),
    .Rot_C    (c),
    .Address  (addr),
    .FreqChng (fc)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } exp_t;

  exp_t              sb[$];
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  int                n_strobe = 0;
  int                n_push   = 0;
  logic [ADDR_W-1:0] m_addr   = '0;
  int                m_idx    = 0;
  int                steps[4] = '{1, 10, 100, 1000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] model_next(input logic [ADDR_W-1:0] cur, input int stp,
                                                   input bit plus);
    int                r;
    logic [ADDR_W-1:0] res;
    r = plus ? int'(cur) + stp : int'(cur) - stp;
`ifndef ROTARY_WRAP_EN
    if (r > 4095) r = 4095;
    if (r < 0) r = 0;
`endif
    res = r[ADDR_W-1:0];
    return res;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fc) begin
        n_strobe++;
        if (sb.size() == 0) begin
          check_val("spurious_strobe", {31'd0, fc}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("strobe_addr", {20'd0, addr}, {20'd0, e.addr});
          check_val("strobe_latency", cyc, e.due);
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        check_val("missed_strobe", cyc, e.due);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_a(input logic v);
    logic [ADDR_W-1:0] nxt;
    if (a === 1'b1 && v === 1'b0) begin
      nxt = model_next(m_addr, steps[m_idx], (b == 1'b0));
      if (nxt != m_addr) begin
        sb.push_back('{nxt, cyc + LAT});
        n_push++;
      end
      m_addr = nxt;
    end
    a = v;
  endtask

  task automatic detent_plus();
    b = 1'b0; wait_cyc(PH);
    drive_a(1'b0); wait_cyc(PH);
    b = 1'b1; wait_cyc(PH);
    drive_a(1'b1); wait_cyc(PH);
  endtask

  task automatic detent_minus();
    drive_a(1'b0); wait_cyc(PH);
    b = 1'b0; wait_cyc(PH);
    drive_a(1'b1); wait_cyc(PH);
    b = 1'b1; wait_cyc(PH);
  endtask

  task automatic pulse_c();
    c = 1'b1; wait_cyc(1);
    c = 1'b0; wait_cyc(6);
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic do_reset();
    rst = 1'b1; wait_cyc(3);
    rst = 1'b0;
    m_addr = '0;
    m_idx  = 0;
    sb.delete();
    wait_cyc(1);
  endtask

  initial begin
    #(42 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a = 1'b1; b = 1'b1; c = 1'b0; rst = 1'b1;
    wait_cyc(2);
    do_reset();
    check_val("rst_addr", {20'd0, addr}, 32'd0);
    check_val("rst_strobe", {31'd0, fc}, 32'd0);

    // minus at 0 saturates (or wraps when enabled)
    for (int i = 0; i < 2; i++) begin
      detent_minus();
      check_val("minus_at_zero", {20'd0, addr}, {20'd0, m_addr});
    end
`ifdef ROTARY_WRAP_EN
    do_reset();
`endif

    for (int i = 0; i < 2; i++) begin
      detent_plus();
      check_val("plus_step1", {20'd0, addr}, {20'd0, m_addr});
    end
    check_val("plus_step1_value", {20'd0, addr}, 32'd2);

    for (int i = 0; i < 5; i++) pulse_c();
    detent_plus();
    check_val("plus_step10", {20'd0, addr}, 32'd12);

    pulse_c();
    pulse_c();
    for (int i = 0; i < 6; i++) begin
      detent_plus();
      check_val("plus_step1000", {20'd0, addr}, {20'd0, m_addr});
    end

    // glitches one cycle shorter than the debounce window
    b = 1'b0; wait_cyc(PH);
    a = 1'b0; wait_cyc(DEB - 1);
    a = 1'b1; wait_cyc(PH);
    b = 1'b1; wait_cyc(PH);
    check_val("glitch_a", {20'd0, addr}, {20'd0, m_addr});
    b = 1'b0; wait_cyc(DEB - 1);
    b = 1'b1; wait_cyc(PH);
    check_val("glitch_b", {20'd0, addr}, {20'd0, m_addr});

    b = 1'b0; wait_cyc(PH);
    do_reset();
    check_val("mid_rot_reset", {20'd0, addr}, 32'd0);
    b = 1'b1; wait_cyc(PH);
    check_val("after_reset_idle", {20'd0, addr}, 32'd0);
    detent_plus();
    check_val("after_reset_plus", {20'd0, addr}, 32'd1);

    wait_cyc(PH);
    check_val("sb_empty", sb.size(), 32'd0);
    check_val("strobe_count", n_strobe, n_push);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
